// File: rtl/alu_selector_pipe.sv
// Two-stage pipelined signed ALU with selectable saturation and a persistent accumulator.
// Stage 1 captures operands; stage 2 computes, registers the result and commits the accumulator.
module alu_selector_pipe #(
    parameter int N_BITS   = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_valid,
    input  logic signed [N_BITS-1:0] i_dataA,
    input  logic signed [N_BITS-1:0] i_dataB,
    input  logic        [2:0]        i_sel,
    input  logic                     i_acc_clr,
    output logic signed [N_BITS-1:0] o_dataC,
    output logic                     o_valid,
    output logic                     o_ovf,
    output logic signed [N_BITS-1:0] o_acc
);

    localparam int SH_W = $clog2(N_BITS);
    localparam logic signed [N_BITS-1:0] MAX_VAL = {1'b0, {(N_BITS-1){1'b1}}};
    localparam logic signed [N_BITS-1:0] MIN_VAL = {1'b1, {(N_BITS-1){1'b0}}};

    logic signed [N_BITS-1:0] r_a;
    logic signed [N_BITS-1:0] r_b;
    logic        [2:0]        r_sel;
    logic                     r_v1;
    logic signed [N_BITS-1:0] r_dataC;
    logic                     r_ovf;
    logic                     r_valid;
    logic signed [N_BITS-1:0] r_acc;

    logic        [N_BITS:0]   w_arith;
    logic                     w_arithOvf;
    logic signed [N_BITS-1:0] w_arithRes;
    logic signed [N_BITS-1:0] w_result;
    logic                     w_ovf;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sel <= '0;
            r_v1  <= 1'b0;
        end else begin
            r_v1 <= i_valid;
            if (i_valid) begin
                r_a   <= i_dataA;
                r_b   <= i_dataB;
                r_sel <= i_sel;
            end
        end
    end

    // Arithmetic ops run one bit wider; disagreeing top bits mean the result left N_BITS range.
    always_comb begin
        w_arith = '0;
        case (r_sel)
            3'd0:    w_arith = {r_a[N_BITS-1], r_a} + {r_b[N_BITS-1], r_b};
            3'd1:    w_arith = {r_a[N_BITS-1], r_a} - {r_b[N_BITS-1], r_b};
            default: w_arith = {r_acc[N_BITS-1], r_acc} + {r_a[N_BITS-1], r_a};
        endcase
        w_arithOvf = w_arith[N_BITS] ^ w_arith[N_BITS-1];
        w_arithRes = w_arith[N_BITS-1:0];
        if (w_arithOvf && SATURATE) begin
            w_arithRes = w_arith[N_BITS] ? MIN_VAL : MAX_VAL;
        end
    end

    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        case (r_sel)
            3'd0, 3'd1, 3'd6: begin
                w_result = w_arithRes;
                w_ovf    = w_arithOvf;
            end
            3'd2:    w_result = r_a & r_b;
            3'd3:    w_result = r_a | r_b;
            3'd4:    w_result = r_a ^ r_b;
            3'd5:    w_result = r_a >>> r_b[SH_W-1:0];
            default: w_result = (r_a > r_b) ? r_a : r_b;
        endcase
    end

    // A clear on the commit edge wins over the op-6 write, but that op still reports its sum.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dataC <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_acc   <= '0;
        end else begin
            r_valid <= r_v1;
            if (r_v1) begin
                r_dataC <= w_result;
                r_ovf   <= w_ovf;
            end
            if (i_acc_clr) begin
                r_acc <= '0;
            end else if (r_v1 && (r_sel == 3'd6)) begin
                r_acc <= w_arithRes;
            end
        end
    end

    assign o_dataC = r_dataC;
    assign o_ovf   = r_ovf;
    assign o_valid = r_valid;
    assign o_acc   = r_acc;

endmodule

// File: tb/tb_alu_selector_pipe.sv
// Bench for alu_selector_pipe: saturating and wrapping instances driven together and
// checked against a transaction-level model of the arithmetic and accumulator rules.
module tb_alu_selector_pipe;

    localparam int N = 16;

    logic                clk;
    logic                rst;
    logic                inValid;
    logic signed [N-1:0] inA;
    logic signed [N-1:0] inB;
    logic        [2:0]   inSel;
    logic                inClr;

    logic signed [N-1:0] dataS, accS, dataW, accW;
    logic                validS, ovfS, validW, ovfW;

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        int     sel;
        longint a;
        longint b;
    } op_t;

    op_t    pend[$];
    longint expAcc[2];
    longint expData[2];
    bit     expOvf[2];
    bit     expValid;

    alu_selector_pipe #(.N_BITS(N), .SATURATE(1'b1)) dutS (
        .i_clk(clk), .i_reset(rst), .i_valid(inValid), .i_dataA(inA), .i_dataB(inB),
        .i_sel(inSel), .i_acc_clr(inClr), .o_dataC(dataS), .o_valid(validS),
        .o_ovf(ovfS), .o_acc(accS)
    );

    alu_selector_pipe #(.N_BITS(N), .SATURATE(1'b0)) dutW (
        .i_clk(clk), .i_reset(rst), .i_valid(inValid), .i_dataA(inA), .i_dataB(inB),
        .i_sel(inSel), .i_acc_clr(inClr), .o_dataC(dataW), .o_valid(validW),
        .o_ovf(ovfW), .o_acc(accW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint toSigned(input logic [N-1:0] v);
        return v[N-1] ? (longint'(v) - (longint'(1) <<< N)) : longint'(v);
    endfunction

    // Reference behaviour expressed with plain integer arithmetic.
    function automatic void modelOp(input int sel, input longint a, input longint b,
                                    input longint acc, input bit sat,
                                    output longint res, output bit ovf);
        longint maxV = (longint'(1) <<< (N - 1)) - 1;
        longint minV = -(longint'(1) <<< (N - 1));
        longint t;
        logic [N-1:0] va, vb, vt;
        va  = a[N-1:0];
        vb  = b[N-1:0];
        ovf = 1'b0;
        res = 0;
        case (sel)
            0, 1, 6: begin
                t = (sel == 0) ? a + b : (sel == 1) ? a - b : acc + a;
                vt = t[N-1:0];
                if (t > maxV || t < minV) begin
                    ovf = 1'b1;
                    res = sat ? ((t > maxV) ? maxV : minV) : toSigned(vt);
                end else begin
                    res = t;
                end
            end
            2: res = toSigned(va & vb);
            3: res = toSigned(va | vb);
            4: res = toSigned(va ^ vb);
            5: res = a >>> (b & longint'((1 << $clog2(N)) - 1));
            default: res = (a > b) ? a : b;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        pend.delete();
        expValid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            expAcc[d]  = 0;
            expData[d] = 0;
            expOvf[d]  = 1'b0;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".validS"}, longint'(validS), longint'(expValid));
        checkOutput({tag, ".validW"}, longint'(validW), longint'(expValid));
        checkOutput({tag, ".dataS"},  longint'(dataS),  expData[0]);
        checkOutput({tag, ".dataW"},  longint'(dataW),  expData[1]);
        checkOutput({tag, ".ovfS"},   longint'(ovfS),   longint'(expOvf[0]));
        checkOutput({tag, ".ovfW"},   longint'(ovfW),   longint'(expOvf[1]));
        checkOutput({tag, ".accS"},   longint'(accS),   expAcc[0]);
        checkOutput({tag, ".accW"},   longint'(accW),   expAcc[1]);
    endtask

    // Drives one cycle of inputs, advances the model through that edge, then checks.
    task automatic applyStimulus(input bit v, input longint a, input longint b,
                                 input int sel, input bit clr, input string tag);
        op_t    p;
        longint res;
        bit     ovf;
        inValid = v;
        inA     = a[N-1:0];
        inB     = b[N-1:0];
        inSel   = 3'(sel);
        inClr   = clr;
        @(posedge clk);
        expValid = 1'b0;
        if (pend.size() > 0) begin
            p = pend.pop_front();
            expValid = 1'b1;
            for (int d = 0; d < 2; d++) begin
                modelOp(p.sel, p.a, p.b, expAcc[d], (d == 0), res, ovf);
                expData[d] = res;
                expOvf[d]  = ovf;
                if (p.sel == 6) expAcc[d] = res;
            end
        end
        if (clr) begin
            expAcc[0] = 0;
            expAcc[1] = 0;
        end
        if (v) pend.push_back('{sel, a, b});
        #1;
        checkAll(tag);
    endtask

    function automatic longint randOperand();
        logic [N-1:0] r;
        case ($urandom_range(0, 5))
            0: r = {1'b0, {(N-1){1'b1}}};
            1: r = {1'b1, {(N-1){1'b0}}};
            2: r = N'($urandom_range(0, 3));
            default: r = N'($urandom);
        endcase
        return toSigned(r);
    endfunction

    initial begin
        modelReset();
        rst = 1'b1; inValid = 1'b0; inA = '0; inB = '0; inSel = '0; inClr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkAll("reset");
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, "idle");

        applyStimulus(1, 1, -4, 0, 0, "add");
        applyStimulus(1, 1, -4, 1, 0, "sub");
        applyStimulus(1, 16'h00F0, 16'h0FF0, 2, 0, "and");
        applyStimulus(1, 16'h00F0, 16'h0FF0, 3, 0, "or");
        applyStimulus(1, 16'h00F0, 16'h0FF0, 4, 0, "xor");
        applyStimulus(1, -16, 2, 5, 0, "sra");
        applyStimulus(1, -3, 2, 7, 0, "max");
        applyStimulus(1, 32767, 1, 0, 0, "addOvf");
        applyStimulus(1, -32768, 1, 1, 0, "subOvf");
        applyStimulus(0, 0, 0, 0, 1, "clr");
        applyStimulus(1, 100, 0, 6, 0, "acc1");
        applyStimulus(1, 200, 0, 6, 0, "acc2");
        applyStimulus(1, -50, 0, 6, 0, "acc3");
        applyStimulus(1, 32767, 0, 6, 0, "accOvf");
        applyStimulus(0, 0, 0, 0, 1, "clr2");
        applyStimulus(1, 250, 0, 6, 0, "acc250");
        applyStimulus(1, 10, 0, 6, 0, "acc10");
        applyStimulus(0, 0, 0, 0, 1, "clrCollide");
        checkOutput("collideData", longint'(dataS), 260);
        checkOutput("collideAcc", longint'(accS), 0);
        applyStimulus(0, 0, 0, 0, 0, "drain");

        applyStimulus(1, 7, 5, 0, 0, "bub1");
        applyStimulus(0, 99, 99, 1, 0, "bub0");
        applyStimulus(1, 3, -9, 0, 0, "bub2");
        applyStimulus(0, 0, 0, 0, 0, "bubHold");
        applyStimulus(0, 0, 0, 0, 0, "bubDrain");

        applyStimulus(1, 5, 6, 0, 0, "flight1");
        applyStimulus(1, 8, 9, 6, 0, "flight2");
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkAll("midReset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, "postReset");

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 4) != 0), randOperand(), randOperand(),
                          int'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0), "rand");
        end
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 0, "final");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
